keypad_debounce_encoder: RTL and testbench



---
 rtl/keypad_debounce_encoder.sv | 183 ++++++++++++++++++
 tb/tb_keypad_debounce_encoder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_debounce_encoder.sv
// Keypad front end: two-flop synchroniser, debounce FSM and priority encoder for
// 20 push buttons, with single-cycle strobe and optional auto-repeat.
module keypad_debounce_encoder #(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_RATE     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] in,
  output logic [4:0]  keycode,
  output logic        strobe,
  output logic        held,
  output logic        multi
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RW = (REPEAT_RATE > 1) ? $clog2(REPEAT_RATE) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);
  localparam logic [15:0]   DELAY16   = 16'(REPEAT_DELAY);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  // Highest set line wins, so the function keys 16-19 override digits.
  function automatic logic [4:0] enc(input logic [19:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 20; i++) begin
      if (v[i]) begin
        idx = 5'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic more_than_one(input logic [19:0] v);
    return (v & (v - 20'd1)) != 20'd0;
  endfunction

  logic [19:0]   meta_r;
  logic [19:0]   sync_r;
  state_t        state_r, state_s;
  logic [4:0]    cand_r, cand_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [15:0]   rcnt_r, rcnt_s, rcnt_inc_s;
  logic [RW-1:0] rate_r, rate_s;
  logic [4:0]    keycode_r, keycode_s;
  logic          strobe_r, strobe_s;
  logic          held_r, held_s;
  logic          multi_r;
  logic [4:0]    key_s;
  logic          any_s;

  assign key_s = enc(sync_r);
  assign any_s = |sync_r;

  // Two-stage synchroniser on the raw button lines plus the registered multi flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r  <= 20'd0;
      sync_r  <= 20'd0;
      multi_r <= 1'b0;
    end else begin
      meta_r  <= in;
      sync_r  <= meta_r;
      multi_r <= more_than_one(sync_r);
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cand_r    <= 5'd0;
      cnt_r     <= '0;
      rcnt_r    <= 16'd0;
      rate_r    <= '0;
      keycode_r <= 5'd0;
      strobe_r  <= 1'b0;
      held_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cand_r    <= cand_s;
      cnt_r     <= cnt_s;
      rcnt_r    <= rcnt_s;
      rate_r    <= rate_s;
      keycode_r <= keycode_s;
      strobe_r  <= strobe_s;
      held_r    <= held_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s    = state_r;
    cand_s     = cand_r;
    cnt_s      = cnt_r;
    rcnt_s     = rcnt_r;
    rate_s     = rate_r;
    keycode_s  = keycode_r;
    strobe_s   = 1'b0;
    held_s     = held_r;
    rcnt_inc_s = (rcnt_r == 16'hFFFF) ? rcnt_r : rcnt_r + 16'd1;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          cand_s  = key_s;
          cnt_s   = '0;
          state_s = DEB_PRESS;
        end else begin
          state_s = IDLE;
        end
      end
      DEB_PRESS: begin
        if (!any_s) begin
          state_s = IDLE;
        end else if (key_s != cand_r) begin
          cand_s = key_s;
          cnt_s  = '0;
        end else if (cnt_r == CNT_LAST) begin
          keycode_s = cand_r;
          strobe_s  = 1'b1;
          held_s    = 1'b1;
          rcnt_s    = 16'd0;
          rate_s    = '0;
          state_s   = HELD;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      HELD: begin
        if (!any_s) begin
          cnt_s   = '0;
          state_s = DEB_RELEASE;
        end else if (REPEAT_EN == 1) begin
          rcnt_s = rcnt_inc_s;
          // Rate counter only runs once the initial delay has elapsed.
          if ((rcnt_inc_s == DELAY16) && (rcnt_r != DELAY16)) begin
            strobe_s = 1'b1;
            rate_s   = '0;
          end else if (rcnt_r >= DELAY16) begin
            if (rate_r == RATE_LAST) begin
              strobe_s = 1'b1;
              rate_s   = '0;
            end else begin
              rate_s = rate_r + RW'(1);
            end
          end else begin
            rate_s = rate_r;
          end
        end else begin
          rcnt_s = rcnt_r;
        end
      end
      DEB_RELEASE: begin
        if (any_s) begin
          state_s = HELD;
        end else if (cnt_r == CNT_LAST) begin
          held_s  = 1'b0;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign keycode = keycode_r;
  assign strobe  = strobe_r;
  assign held    = held_r;
  assign multi   = multi_r;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Self-checking bench: directed scenarios with literal expectations plus random
// stimulus compared every cycle against a run-length behavioural model.
module tb_keypad_debounce_encoder;

  localparam int D    = 3;
  localparam int DLY  = 8;
  localparam int RATE = 4;

  logic        clk;
  logic        rst;
  logic [19:0] in;
  logic [4:0]  keycode;
  logic        strobe;
  logic        held;
  logic        multi;

  int tests = 0;
  int fails = 0;

  keypad_debounce_encoder #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_EN(1),
    .REPEAT_DELAY(DLY),
    .REPEAT_RATE(RATE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(in),
    .keycode(keycode),
    .strobe(strobe),
    .held(held),
    .multi(multi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a press is accepted once D+1 consecutive synchronised
  // samples show the same nonzero key; a release once D+1 consecutive zeros are
  // seen. Repeat count advances on held cycles whose sample and previous sample
  // are both nonzero.
  logic [19:0] s1_m, s2_m;
  bit          prev_nz;
  int          prev_key, run_len, zero_len, rep_n;
  bit          held_m, exp_strobe, exp_multi;
  logic [4:0]  exp_key;

  task automatic model_clear();
    s1_m = 20'h0; s2_m = 20'h0;
    prev_nz = 1'b0; prev_key = 0; run_len = 0; zero_len = 0; rep_n = 0;
    held_m = 1'b0; exp_strobe = 1'b0; exp_multi = 1'b0; exp_key = 5'd0;
  endtask

  task automatic model_step();
    logic [19:0] s;
    bit nz;
    int k;
    s = s2_m; s2_m = s1_m; s1_m = in;
    nz = (s != 20'h0);
    k = nz ? ($clog2(int'(s) + 1) - 1) : 0;
    if (nz) begin
      run_len = (prev_nz && k == prev_key) ? run_len + 1 : 1;
      zero_len = 0;
    end else begin
      zero_len++;
      run_len = 0;
    end
    exp_strobe = 1'b0;
    exp_multi = ($countones(s) > 1);
    if (!held_m) begin
      if (nz && run_len == D + 1) begin
        held_m = 1'b1; exp_key = 5'(k); exp_strobe = 1'b1; rep_n = 0;
      end
    end else if (nz && prev_nz) begin
      rep_n++;
      if (rep_n == DLY || (rep_n > DLY && (rep_n - DLY) % RATE == 0)) exp_strobe = 1'b1;
    end else if (!nz && zero_len == D + 1) begin
      held_m = 1'b0;
    end
    prev_nz = nz; prev_key = k;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_clear();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cmp_strobe",  32'(strobe),  32'(exp_strobe));
      check("cmp_keycode", 32'(keycode), 32'(exp_key));
      check("cmp_held",    32'(held),    32'(held_m));
      check("cmp_multi",   32'(multi),   32'(exp_multi));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, actual %0t required < 1000000", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in = 20'h0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_keycode"}, 32'(keycode), 32'd0);
    check({tag, "_strobe"},  32'(strobe),  32'd0);
    check({tag, "_held"},    32'(held),    32'd0);
    check({tag, "_multi"},   32'(multi),   32'd0);
  endtask

  initial begin
    int scount;
    rst = 1'b1;
    in  = 20'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle_cycles(4);

    // Clean press of key 5
    @(negedge clk); in = 20'h00020;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (e == 5) check("press_early", 32'(strobe), 32'd0);
      if (e == 6) begin
        check("press_strobe", 32'(strobe), 32'd1);
        check("press_key", 32'(keycode), 32'd5);
        check("press_held", 32'(held), 32'd1);
        check("model_press", 32'(exp_strobe), 32'd1);
      end
    end
    in = 20'h0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      if (e == 5) check("release_held_hi", 32'(held), 32'd1);
      if (e == 6) begin
        check("release_held_lo", 32'(held), 32'd0);
        check("model_release", 32'(held_m), 32'd0);
      end
    end

    // Bounce on key 7
    scount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in = (i % 2 == 0) ? 20'h00080 : 20'h0;
      if (strobe) scount++;
    end
    @(negedge clk); in = 20'h00080;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (e <= 5 && strobe) scount++;
      if (e == 6) begin
        check("bounce_quiet", 32'(scount), 32'd0);
        check("bounce_strobe", 32'(strobe), 32'd1);
        check("bounce_key", 32'(keycode), 32'd7);
      end
    end
    idle_cycles(10);

    // Priority: keys 2 and 16, then key 2 alone while held
    @(negedge clk); in = 20'h10004;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      if (e == 6) begin
        check("prio_strobe", 32'(strobe), 32'd1);
        check("prio_key", 32'(keycode), 32'd16);
        in = 20'h00004;
      end
      if (e == 7) check("prio_multi", 32'(multi), 32'd1);
      if (e >= 7) begin
        check("prio_nostrobe", 32'(strobe), 32'd0);
        check("prio_keep", 32'(keycode), 32'd16);
      end
    end
    idle_cycles(10);

    // Auto-repeat on key 18
    @(negedge clk); in = 20'h40000;
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      check("repeat_strobe", 32'(strobe),
            32'(((e == 6) || (e >= 14 && (e - 14) % 4 == 0)) ? 1 : 0));
      if (e >= 6) check("repeat_key", 32'(keycode), 32'd18);
    end
    idle_cycles(10);

    // Release glitch on key 3
    @(negedge clk); in = 20'h00008;
    for (int e = 1; e <= 13; e++) begin
      @(negedge clk);
      if (e == 7) in = 20'h0;
      if (e == 8) in = 20'h00008;
      if (e >= 8) begin
        check("glitch_held", 32'(held), 32'd1);
        check("glitch_nostrobe", 32'(strobe), 32'd0);
      end
    end
    in = 20'h0;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      if (e == 5) check("drop_held_hi", 32'(held), 32'd1);
      if (e == 6) check("drop_held_lo", 32'(held), 32'd0);
    end
    in = 20'h00008;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (e == 6) begin
        check("repress_strobe", 32'(strobe), 32'd1);
        check("repress_key", 32'(keycode), 32'd3);
      end
    end
    idle_cycles(10);

    // Reset during DEB_PRESS, then during HELD, with key 9 held throughout
    @(negedge clk); in = 20'h00200;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_deb");
    @(negedge clk); rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (e == 5) check("rst1_early", 32'(strobe), 32'd0);
      if (e == 6) begin
        check("rst1_strobe", 32'(strobe), 32'd1);
        check("rst1_key", 32'(keycode), 32'd9);
      end
    end
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_held");
    @(negedge clk); rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      if (e == 6) begin
        check("rst2_strobe", 32'(strobe), 32'd1);
        check("rst2_key", 32'(keycode), 32'd9);
      end
    end
    idle_cycles(10);

    // Random segments checked by the model
    for (int seg = 0; seg < 150; seg++) begin
      int kind, len;
      logic [19:0] pat;
      kind = $urandom_range(0, 4);
      len  = $urandom_range(1, 25);
      case (kind)
        0: pat = 20'h0;
        1: pat = 20'h1 << $urandom_range(0, 19);
        2: pat = (20'h1 << $urandom_range(0, 19)) | (20'h1 << $urandom_range(0, 19));
        3: pat = 20'h1 << $urandom_range(0, 19);
        default: pat = 20'($urandom);
      endcase
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        in = (kind == 3 && c % 2 == 1) ? 20'h0 : pat;
      end
      if ($urandom_range(0, 30) == 0) begin
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    idle_cycles(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
